// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter for a burst-oriented shared
// resource. A grant covers whole transactions (ending on xfer & last). The
// holder may keep the grant for up to its weight in back-to-back transactions.
// After that the grant rotates, and the next owner is granted with no idle
// cycle.
// Optional idle-beat watchdog: define WRR_TIMEOUT_EN.
module wrr_burst_arbiter #(
  parameter int NREQ    = 4,
  parameter int WW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    last,
  input  logic                    xfer,
  input  logic [NREQ*WW-1:0]      cfg_weight,
  input  logic                    cfg_load,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WW-1:0]   credit_q, credit_d;
  logic [WW-1:0]   weight_q [NREQ];

  logic            arb_found;
  logic [IW-1:0]   arb_winner;
  int              arb_idx;

  logic            end_txn;
  logic            take_new;
  logic            tmo_hit;
  logic            tmo_err_q;

  // A weight of zero would starve nobody but would break the credit count.
  // Zero is therefore treated as one.
  function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  // Rotating-priority search: first asserted request at or after ptr wins.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!arb_found && req[arb_idx]) begin
        arb_found  = 1'b1;
        arb_winner = IW'(arb_idx);
      end
    end
  end

  // State register plus grant/pointer/credit/weight registers.
  // NOTE: sequential logic uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      credit_q <= '0;
      // NOTE: the weight file is reset (not left undefined).
      // Until software programs it, every requester starts with weight 1.
      for (int i = 0; i < NREQ; i++) weight_q[i] <= WW'(1);
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      credit_q <= credit_d;
      if (cfg_load) begin
        for (int i = 0; i < NREQ; i++) weight_q[i] <= cfg_weight[i*WW +: WW];
      end
    end
  end

  // Next-state logic: hold on credit, otherwise re-arbitrate in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first.
    // No path can leave a latch behind.
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    gnt_d    = gnt_q;
    credit_d = credit_q;
    end_txn  = xfer & last;
    take_new = 1'b0;

    case (state_q)
      IDLE: take_new = 1'b1;
      GRANT: begin
        if (tmo_hit) begin
          take_new = 1'b1;
        end else if (end_txn) begin
          if (credit_q > WW'(1) && req[id_q]) credit_d = credit_q - WW'(1);
          else                                take_new = 1'b1;
        end else if (!req[id_q]) begin
          // Requester abandoned its burst: release without waiting for last.
          take_new = 1'b1;
        end
      end
      default: take_new = 1'b1;
    endcase

    if (take_new) begin
      if (arb_found) begin
        state_d  = GRANT;
        id_d     = arb_winner;
        gnt_d    = NREQ'(1) << arb_winner;
        ptr_d    = (arb_winner == IW'(NREQ - 1)) ? '0 : arb_winner + IW'(1);
        credit_d = eff_weight(weight_q[arb_winner]);
      end else begin
        state_d  = IDLE;
        id_d     = '0;
        gnt_d    = '0;
        credit_d = '0;
      end
    end
  end

`ifdef WRR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q;

  // The stall would bring the count to TIMEOUT on this edge.
  // Force the release now and pulse the error on the same edge.
  assign tmo_hit = (state_q == GRANT) && !xfer && (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Watchdog: counts GRANT cycles without a beat, cleared by any beat or new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
      if (xfer || take_new || state_q != GRANT) tmo_cnt_q <= '0;
      else                                      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  // Watchdog compiled out: a stalled slave keeps the grant indefinitely.
  // TIMEOUT stays referenced so both builds share one parameter set.
  assign tmo_hit   = 1'b0;
  assign tmo_err_q = 1'b0 & (TIMEOUT > 0);
`endif

  // Output decode from registered state.
  always_comb begin
    gnt         = gnt_q;
    gnt_id      = id_q;
    busy        = (state_q == GRANT);
    timeout_err = tmo_err_q;
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: directed stimulus for wrr_burst_arbiter.
// Each driven cycle pushes the hand-computed outputs expected after the next
// clock edge. An independent monitor pops and compares them on the falling edge.
module tb_wrr_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        last;
  logic        xfer;
  logic [15:0] cfg_weight;
  logic        cfg_load;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  wrr_burst_arbiter #(.NREQ(4), .WW(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .last        (last),
    .xfer        (xfer),
    .cfg_weight  (cfg_weight),
    .cfg_load    (cfg_load),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Apply inputs for one cycle and queue the outputs expected after its edge.
  task automatic drive(input logic [3:0] r, input logic x, input logic l,
                       input logic [3:0] eg, input logic et, input string nm);
    exp_t e;
    req  = r;
    xfer = x;
    last = l;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.tmo  = et;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  initial begin
    exp_t       e;
    logic       eb;
    logic [1:0] eid;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        eb  = |e.gnt;
        eid = onehot_idx(e.gnt);
        n_cmp++;
        if (e.cyc != cyc || gnt !== e.gnt || busy !== eb || timeout_err !== e.tmo ||
            (eb && gnt_id !== eid)) begin
          n_bad++;
          $display("FAIL %s cyc=%0d(due %0d): got gnt=%b busy=%b gnt_id=%0d timeout_err=%b, want gnt=%b busy=%b gnt_id=%0d timeout_err=%b",
                   e.name, cyc, e.cyc, gnt, busy, gnt_id, timeout_err, e.gnt, eb, eid, e.tmo);
        end
      end
    end
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; xfer = 1'b0; last = 1'b0; cfg_load = 1'b0; cfg_weight = '0;
    @(posedge clk);
    #1;

    // Reset state
    drive(4'b0000, 0, 0, 4'b0000, 0, "reset");
    rst = 1'b0;

    // Default weights, two requesters, single-beat transactions
    drive(4'b0011, 0, 0, 4'b0001, 0, "t1_first_grant");
    drive(4'b0011, 1, 1, 4'b0010, 0, "t1_rot1");
    drive(4'b0011, 1, 1, 4'b0001, 0, "t1_rot2");
    drive(4'b0011, 1, 1, 4'b0010, 0, "t1_rot3");
    drive(4'b0011, 1, 1, 4'b0001, 0, "t1_rot4");
    drive(4'b0011, 1, 1, 4'b0010, 0, "t1_rot5");
    drive(4'b0000, 0, 0, 4'b0000, 0, "t1_idle");
    drive(4'b0000, 1, 1, 4'b0000, 0, "xfer_while_idle");

    // Weight 0 behaves as weight 1 (ptr is 2 here)
    cfg_weight = 16'h0000; cfg_load = 1'b1;
    drive(4'b0000, 0, 0, 4'b0000, 0, "w0_load");
    cfg_load = 1'b0;
    drive(4'b0011, 0, 0, 4'b0001, 0, "w0_grant");
    drive(4'b0011, 1, 1, 4'b0010, 0, "w0_rot1");
    drive(4'b0011, 1, 1, 4'b0001, 0, "w0_rot2");
    drive(4'b0000, 0, 0, 4'b0000, 0, "w0_idle");

    // Weights {1,1,1,3}, all requesting, single-beat transactions
    rst = 1'b1;
    drive(4'b0000, 0, 0, 4'b0000, 0, "t2_reset");
    rst = 1'b0;
    cfg_weight = 16'h1113; cfg_load = 1'b1;
    drive(4'b0000, 0, 0, 4'b0000, 0, "t2_load");
    cfg_load = 1'b0;
    drive(4'b1111, 0, 0, 4'b0001, 0, "t2_grant0");
    drive(4'b1111, 1, 1, 4'b0001, 0, "t2_hold0a");
    drive(4'b1111, 1, 1, 4'b0001, 0, "t2_hold0b");
    drive(4'b1111, 1, 1, 4'b0010, 0, "t2_g1");
    drive(4'b1111, 1, 1, 4'b0100, 0, "t2_g2");
    drive(4'b1111, 1, 1, 4'b1000, 0, "t2_g3");
    drive(4'b1111, 1, 1, 4'b0001, 0, "t2_g0_again");
    drive(4'b1111, 1, 1, 4'b0001, 0, "t2_hold0c");
    drive(4'b1111, 1, 1, 4'b0001, 0, "t2_hold0d");
    drive(4'b1111, 1, 1, 4'b0010, 0, "t2_g1_again");
    drive(4'b0000, 0, 0, 4'b0000, 0, "t2_idle");

    // 4-beat burst, req1 arrives mid-burst, zero-bubble handover
    rst = 1'b1;
    drive(4'b0000, 0, 0, 4'b0000, 0, "t3_reset");
    rst = 1'b0;
    drive(4'b0001, 0, 0, 4'b0001, 0, "t3_grant0");
    drive(4'b0001, 1, 0, 4'b0001, 0, "t3_beat1");
    drive(4'b0011, 1, 0, 4'b0001, 0, "t3_beat2_no_preempt");
    drive(4'b0011, 1, 0, 4'b0001, 0, "t3_beat3");
    drive(4'b0011, 0, 1, 4'b0001, 0, "t3_last_without_xfer");
    drive(4'b0011, 1, 1, 4'b0010, 0, "t3_handover");
    drive(4'b0010, 1, 1, 4'b0010, 0, "t3_repick_alone");
    drive(4'b0010, 1, 0, 4'b0010, 0, "t5_beat1");
    drive(4'b0000, 0, 0, 4'b0000, 0, "t5_abort_idle");

    // Wrap-around: grant req2 so ptr=3, then req3 before req0
    drive(4'b0100, 0, 0, 4'b0100, 0, "t4_grant2");
    drive(4'b1101, 1, 1, 4'b1000, 0, "t4_wrap_g3");
    drive(4'b1001, 1, 1, 4'b0001, 0, "t4_wrap_g0");
    drive(4'b0001, 1, 1, 4'b0001, 0, "t4_g0_alone");
    drive(4'b0000, 0, 0, 4'b0000, 0, "t4_idle");

    // Synchronous reset mid-burst
    drive(4'b0100, 0, 0, 4'b0100, 0, "t5_grant2");
    drive(4'b0100, 1, 0, 4'b0100, 0, "t5_burst_beat1");
    rst = 1'b1;
    drive(4'b0100, 1, 0, 4'b0000, 0, "t5_reset_mid_burst");
    rst = 1'b0;
    drive(4'b1100, 0, 0, 4'b0100, 0, "t5_ptr_cleared");
    drive(4'b1100, 1, 1, 4'b1000, 0, "t5_rot3");
    drive(4'b0000, 0, 0, 4'b0000, 0, "t5_idle");

`ifdef WRR_TIMEOUT_EN
    // Stalled slave: release on the 16th stall cycle with a one-cycle error pulse
    drive(4'b0110, 0, 0, 4'b0010, 0, "tmo_grant1");
    for (int i = 1; i <= 15; i++) drive(4'b0110, 0, 0, 4'b0010, 0, "tmo_stall");
    drive(4'b0110, 0, 0, 4'b0100, 1, "tmo_release");
    drive(4'b0110, 0, 0, 4'b0100, 0, "tmo_pulse_end");
    drive(4'b0000, 0, 0, 4'b0000, 0, "tmo_idle");
`else
    // Stalled slave without watchdog: grant held, no error
    drive(4'b0010, 0, 0, 4'b0010, 0, "hold_grant1");
    for (int i = 0; i < 100; i++) drive(4'b0010, 0, 0, 4'b0010, 0, "hold_stall");
    drive(4'b0000, 0, 0, 4'b0000, 0, "hold_idle");
`endif

    req = '0; xfer = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one burst-oriented bus/resource between NREQ requesters.
- A grant is held for a whole transaction, which ends on the beat where `xfer` and `last` are both high.
- A requester may keep the grant for up to its programmed weight of back-to-back transactions before the grant rotates.
- Sits in front of the shared slave. It is the sequencing successor to the fixed 4-way round-robin grant logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WW, 4, width of each weight/credit field.
- TIMEOUT, 16, idle-beat watchdog limit. Used only with WRR_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester. Held high until its last beat completes.
- last  input  1  final beat of the granted requester's current transaction.
- xfer  input  1  beat accepted by the shared resource this cycle.
- cfg_weight  input  NREQ*WW  weights. Field i = bits [i*WW +: WW].
- cfg_load  input  1  capture cfg_weight into the internal weight registers.
- gnt  output  NREQ  one-hot registered grant.
- gnt_id  output  $clog2(NREQ)  binary index of the granted requester. Valid when busy=1.
- busy  output  1  a grant is active.
- timeout_err  output  1  one-cycle pulse on watchdog release. Tied 0 without the macro.

Behaviour:
- Reset:
  - gnt=0, gnt_id=0, busy=0, timeout_err=0.
  - State IDLE, pointer ptr=0, credit=0.
  - All weight registers = 1.
- Weights:
  - cfg_load samples cfg_weight on the clock edge.
  - New weights apply only at the next credit load; the in-flight credit is unchanged.
  - A weight of 0 is treated as 1.
- Arbitration:
  - Search starts at ptr and proceeds ptr, ptr+1, … modulo NREQ.
  - The first asserted req wins.
  - On a win: ptr <= winner+1 (wraps NREQ-1 -> 0) and credit <= weight[winner].
- State IDLE:
  - If any req is high, the arbitration result is registered. gnt/gnt_id/busy are valid the next cycle (1-cycle latency). Go to GRANT.
  - Otherwise outputs stay 0.
- State GRANT:
  - gnt is stable. Beats with xfer=1, last=0 do not change state.
- Transaction end (xfer=1, last=1):
  - If credit>1 and req[gnt_id] is still high: credit-- and the grant is held (same gnt next cycle).
  - Otherwise release.
- Release:
  - Arbitration is recomputed in the same cycle using the updated ptr.
  - A new winner's grant appears the very next cycle (zero-bubble handover), so the releasing requester is picked again only if no other req is high.
  - If no req is high: gnt=0, busy=0, go to IDLE.
- Abort:
  - If req[gnt_id] falls while in GRANT with no xfer&last that cycle, release next edge as above.
  - The partial burst is abandoned; this is a protocol error and not flagged.
- Other rules:
  - xfer while busy=0 is ignored.
  - last without xfer is ignored.
  - Requests arriving mid-transaction never pre-empt the current grant.
  - Synchronous rst asserted mid-burst forces the reset values on the next edge, regardless of xfer.
  - gnt is always one-hot or zero, and gnt_id is consistent with it.

Optional Feature:
- Macro: WRR_TIMEOUT_EN.
- Defined:
  - A counter clears on every xfer and on every new grant, and increments each GRANT cycle without xfer.
  - When it reaches TIMEOUT, the grant is force-released (normal rotation, credit discarded) and timeout_err pulses for 1 cycle, coincident with the release edge.
- Undefined:
  - No counter logic; timeout_err is constant 0.
  - A stalled slave holds the grant indefinitely.

Test Plan:
- Reset, weights default 1; req=0011, single-beat transactions (xfer=last=1 every cycle) -> gnt sequence 0001,0010,0001,0010…, with the first grant 1 cycle after req.
- cfg_load weights {1,1,1,3} (req3..req0), all req high, single-beat transactions -> gnt pattern 0001 x3, 0010, 0100, 1000, repeat.
- req0 only, 4-beat burst (last on beat 4), weight 1; req1 rises on beat 2 -> gnt=0001 through beat 4, then gnt=0010 on the cycle after beat 4 with no idle cycle.
- Wrap-around: ptr at 3 after granting req2; req=1001 -> gnt=1000 first, then 0001.
- Granted requester drops req mid-burst with no other req -> gnt=0, busy=0 the next cycle. Synchronous rst asserted on beat 2 of a burst -> all outputs 0 the next cycle.
- WRR_TIMEOUT_EN defined, TIMEOUT=16: grant req1, hold xfer=0 -> the grant releases on the 16th stall cycle, timeout_err=1 for one cycle, gnt moves to the next requester. Without the macro -> grant held after 100 cycles, timeout_err=0.
